execute_muldiv_unit: RTL and testbench
======================================

// Module: execute_muldiv_unit
// PURPOSE
//   Parametrised multi-cycle multiply/divide unit with integrated HI/LO registers.
//   Successor to the single-cycle ALU HI/LO path in the Execute stage; adds DIV/DIVU.
//   Also adds signed/unsigned multiply, MADD/MSUB accumulate, a start/busy/done handshake,
//   a pipeline stall request and flush.
//   Sits beside the ALU in Execute. Operands come from the forwarding muxes.
//   Hi/Lo feed MFHI/MFLO.
// PARAMETERS
//   WIDTH     32  operand width; Hi and Lo are each WIDTH bits; product is 2*WIDTH
//   CNT_W     6   iteration-counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//   Clk     in   1      clock, rising edge
//   Rst     in   1      asynchronous, active-high reset
//   Start   in   1      launch Op with A/B this cycle (honoured only in IDLE)
//   Op      in   3      0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MSUB, 6 MTHI, 7 MTLO
//   A       in   WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO data)
//   B       in   WIDTH  rt operand (divisor / multiplier)
//   Flush   in   1      abort any in-flight op
//   Busy    out  1      1 while in RUN or FIXUP
//   Done    out  1      one-cycle pulse on the cycle new Hi/Lo are first visible
//   Stall   out  1      Busy | (Start & IDLE & Op<=5); holds the pipeline front end
//   Hi      out  WIDTH  HI register
//   Lo      out  WIDTH  LO register
// BEHAVIOUR
//   Reset: state IDLE; Hi=0, Lo=0, Busy=0, Done=0; counter=0. Asserting Rst mid-op aborts the op.
//   FSM: IDLE -(Start & Op<=5)-> RUN -(counter==WIDTH-1)-> FIXUP -> IDLE.
//   IDLE / Op 6,7: MTHI/MTLO write A into Hi/Lo on the next edge. No Busy, no Done, no Stall.
//   Latching: A, B and Op are latched at the Start edge; later input changes are ignored.
//   RUN: radix-2 iteration, one bit per cycle, exactly WIDTH cycles.
//   Signed ops (0, 2, 4, 5) iterate on magnitudes and record the result signs.
//   FIXUP: 1 cycle. Applies sign correction.
//     MADD: {Hi,Lo} += signed A*B, wrapping mod 2**(2*WIDTH).
//     MSUB: {Hi,Lo} -= signed A*B, wrapping mod 2**(2*WIDTH).
//     Hi/Lo are written on the FIXUP->IDLE edge; Done=1 for the following cycle only.
//   Latency: Start sampled at edge 0 -> Hi/Lo updated and Done high after edge WIDTH+1.
//   Multiply: {Hi,Lo} = full 2*WIDTH-bit product.
//   Divide: Lo = quotient, Hi = remainder.
//     Truncating division; remainder takes the dividend's sign.
//   Divide by zero (B==0), all divides: Lo = {WIDTH{1}}, Hi = A.
//     Completes with normal latency, no trap.
//   Signed overflow (A = -2**(WIDTH-1), B = -1): Lo = A, Hi = 0.
//   Hi/Lo hold their old values throughout RUN/FIXUP. Reads during Busy return the old values.
//   Start while Busy is ignored; software/hazard unit relies on Stall.
//   Flush: any state -> IDLE on the next edge. Hi/Lo unchanged, no Done.
//     Flush wins over a same-cycle Start.
//     Flush in the FIXUP cycle also suppresses the Hi/Lo write.
//   Stall is combinational; it deasserts in the Done cycle so the pipeline resumes exactly then.
// TESTING (WIDTH=32)
//   Reset mid-RUN of MULT -> Hi=0, Lo=0, Busy=0 immediately; no Done afterwards.
//   MULTU A=FFFFFFFF B=FFFFFFFF -> after 33 edges: Hi=FFFFFFFE, Lo=00000001, Done=1 for one cycle.
//   MULT A=FFFFFFFD(-3) B=7 -> Hi=FFFFFFFF, Lo=FFFFFFEB.
//   DIV A=FFFFFFF9(-7) B=2 -> Lo=FFFFFFFD, Hi=FFFFFFFF.
//   DIVU A=0000000A B=0 -> Lo=FFFFFFFF, Hi=0000000A.
//   DIV A=80000000 B=FFFFFFFF -> Lo=80000000, Hi=0.
//   MTHI 5, MTLO 0, then MADD A=2 B=3 -> Hi=5, Lo=6.
//   MSUB A=1 B=7 from Hi=0, Lo=3 -> Hi=FFFFFFFF, Lo=FFFFFFFC.
//   Start DIVU, Flush at RUN cycle 10 -> IDLE next edge, Hi/Lo unchanged, Done never asserted.
//   Start asserted again during Busy -> ignored; result matches the first op.

Source files
------------

// File: rtl/execute_muldiv_unit.sv
// Multi-cycle radix-2 multiply/divide unit with HI/LO registers for the Execute stage.
// Signed ops iterate on magnitudes; sign correction and MADD/MSUB accumulate happen in FIXUP.
module execute_muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             flush_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             stall_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MADD  = 3'd4;
   localparam logic [2:0] OP_MSUB  = 3'd5;
   localparam logic [2:0] OP_MTHI  = 3'd6;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_FIXUP = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2:0]         op_q, op_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]   a_raw_q, a_raw_d;
   logic               q_neg_q, q_neg_d;
   logic               r_neg_q, r_neg_d;
   logic               div0_q, div0_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               done_q, done_d;

   logic               op_signed_s, op_long_s, op_is_div_s, run_is_div_s;
   logic               a_neg_s, b_neg_s;
   logic [WIDTH-1:0]   a_mag_s, b_mag_s, mcand_sel_s;
   logic [WIDTH:0]     mul_sum_s, div_diff_s;
   logic [2*WIDTH-1:0] step_s, prod_s, fix_s;

   assign op_long_s    = (op_i <= OP_MSUB);
   assign op_is_div_s  = (op_i == OP_DIV) || (op_i == OP_DIVU);
   assign run_is_div_s = (op_q == OP_DIV) || (op_q == OP_DIVU);

   // Operand conditioning: signs and magnitudes of the incoming operands
   always_comb begin
      op_signed_s = (op_i == OP_MULT) || (op_i == OP_DIV) ||
                    (op_i == OP_MADD) || (op_i == OP_MSUB);
      a_neg_s = op_signed_s & a_i[WIDTH-1];
      b_neg_s = op_signed_s & b_i[WIDTH-1];
      if (a_neg_s) a_mag_s = -a_i;
      else         a_mag_s = a_i;
      if (b_neg_s) b_mag_s = -b_i;
      else         b_mag_s = b_i;
   end

   // One radix-2 step: shift-add for multiply, restoring subtract for divide
   always_comb begin
      if (acc_q[0]) mcand_sel_s = mcand_q;
      else          mcand_sel_s = {WIDTH{1'b0}};
      mul_sum_s  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_sel_s};
      div_diff_s = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, mcand_q};
      if (run_is_div_s) begin
         if (div_diff_s[WIDTH]) step_s = {acc_q[2*WIDTH-2:0], 1'b0};
         else                   step_s = {div_diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
         step_s = {mul_sum_s, acc_q[WIDTH-1:1]};
      end
   end

   // Sign correction and accumulate, producing the {Hi,Lo} value written at FIXUP
   always_comb begin
      if (q_neg_q) prod_s = -acc_q;
      else         prod_s = acc_q;
      fix_s = prod_s;
      case (op_q)
         OP_MADD: fix_s = {hi_q, lo_q} + prod_s;
         OP_MSUB: fix_s = {hi_q, lo_q} - prod_s;
         OP_DIV, OP_DIVU: begin
            if (div0_q) begin
               fix_s = {a_raw_q, {WIDTH{1'b1}}};
            end else begin
               if (q_neg_q) fix_s[WIDTH-1:0] = -acc_q[WIDTH-1:0];
               else         fix_s[WIDTH-1:0] = acc_q[WIDTH-1:0];
               if (r_neg_q) fix_s[2*WIDTH-1:WIDTH] = -acc_q[2*WIDTH-1:WIDTH];
               else         fix_s[2*WIDTH-1:WIDTH] = acc_q[2*WIDTH-1:WIDTH];
            end
         end
         default: fix_s = prod_s;
      endcase
   end

   // Next-state logic for the sequencer, operand latches and HI/LO
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      acc_d   = acc_q;
      mcand_d = mcand_q;
      a_raw_d = a_raw_q;
      q_neg_d = q_neg_q;
      r_neg_d = r_neg_q;
      div0_d  = div0_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      if (flush_i) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_i && op_long_s) begin
                  state_d = S_RUN;
                  cnt_d   = {CNT_W{1'b0}};
                  op_d    = op_i;
                  a_raw_d = a_i;
                  q_neg_d = a_neg_s ^ b_neg_s;
                  r_neg_d = a_neg_s;
                  div0_d  = (b_i == {WIDTH{1'b0}});
                  if (op_is_div_s) begin
                     acc_d   = {{WIDTH{1'b0}}, a_mag_s};
                     mcand_d = b_mag_s;
                  end else begin
                     acc_d   = {{WIDTH{1'b0}}, b_mag_s};
                     mcand_d = a_mag_s;
                  end
               end else if (start_i) begin
                  if (op_i == OP_MTHI) hi_d = a_i;
                  else                 lo_d = a_i;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_RUN: begin
               acc_d = step_s;
               cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
               if (cnt_q == CNT_W'(WIDTH-1)) state_d = S_FIXUP;
               else                          state_d = S_RUN;
            end
            S_FIXUP: begin
               hi_d    = fix_s[2*WIDTH-1:WIDTH];
               lo_d    = fix_s[WIDTH-1:0];
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State and datapath registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= {CNT_W{1'b0}};
         op_q    <= 3'd0;
         acc_q   <= {(2*WIDTH){1'b0}};
         mcand_q <= {WIDTH{1'b0}};
         a_raw_q <= {WIDTH{1'b0}};
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
         div0_q  <= 1'b0;
         hi_q    <= {WIDTH{1'b0}};
         lo_q    <= {WIDTH{1'b0}};
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         acc_q   <= acc_d;
         mcand_q <= mcand_d;
         a_raw_q <= a_raw_d;
         q_neg_q <= q_neg_d;
         r_neg_q <= r_neg_d;
         div0_q  <= div0_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   assign busy_o  = (state_q != S_IDLE);
   assign done_o  = done_q;
   assign hi_o    = hi_q;
   assign lo_o    = lo_q;
   // Stall is combinational so a launching op holds the front end in its own issue cycle
   assign stall_o = busy_o | (start_i & (state_q == S_IDLE) & op_long_s);

endmodule

// File: tb/tb_execute_muldiv_unit.sv
// Bench for execute_muldiv_unit: spec vector table, reference-model random ops,
// and hand sequences for reset, flush and Start-while-busy.
module tb_execute_muldiv_unit;
   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst, start, flush;
   logic [2:0]    op;
   logic [W-1:0]  a, b;
   logic          busy, done, stall;
   logic [W-1:0]  hi, lo;

   int            checks;
   int            errors;
   logic [63:0]   exp_q[$];

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a, b, pre_hi, pre_lo, exp_hi, exp_lo;
   } vec_t;
   vec_t vecs[12];

   execute_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
      .flush_i(flush), .busy_o(busy), .done_o(done), .stall_o(stall),
      .hi_o(hi), .lo_o(lo)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic move_to(input logic [2:0] o, input logic [31:0] d);
      start = 1'b1; op = o; a = d; b = $urandom;
      #1;
      check("mt_stall", 64'(stall), 64'd0);
      tick();
      start = 1'b0;
   endtask

   task automatic preset(input logic [31:0] ph, input logic [31:0] pl);
      move_to(3'd6, ph);
      move_to(3'd7, pl);
      check("preset_val", {hi, lo}, {ph, pl});
      check("preset_ctl", 64'({busy, done}), 64'd0);
   endtask

   task automatic launch(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [63:0] e);
      exp_q.push_back(e);
      start = 1'b1; op = o; a = x; b = y;
      #1;
      check("stall_launch", 64'(stall), 64'd1);
      tick();
      start = 1'b0;
      a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
   endtask

   task automatic wait_done(input string name, input bit poke);
      int n;
      logic [63:0] held;
      logic [63:0] e;
      n = 0;
      held = {hi, lo};
      while (!done && n < 40) begin
         if (poke && n == 5) begin start = 1'b1; op = 3'd2; a = 32'd7; b = 32'd2; end
         if (poke && n == 8) start = 1'b0;
         tick();
         n++;
         if (n == 10) begin
            check({name, "_busy"}, 64'(busy), 64'd1);
            check({name, "_hold"}, {hi, lo}, held);
         end
      end
      check({name, "_lat"}, 64'(n), 64'd33);
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = 64'd0;
      check({name, "_done"}, 64'(done), 64'd1);
      if (done) begin
         check({name, "_res"}, {hi, lo}, e);
         check({name, "_stall"}, 64'({stall, busy}), 64'd0);
         tick();
         check({name, "_pulse"}, 64'(done), 64'd0);
      end
   endtask

   function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x,
                                         input logic [31:0] y, input logic [31:0] ph,
                                         input logic [31:0] pl);
      int sx, sy;
      longint p;
      sx = x; sy = y;
      p = longint'(sx) * longint'(sy);
      case (o)
         3'd0: model = p;
         3'd1: model = {32'd0, x} * {32'd0, y};
         3'd2: begin
            if (y == 32'd0) model = {x, 32'hFFFF_FFFF};
            else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) model = {32'd0, x};
            else model = {32'(sx % sy), 32'(sx / sy)};
         end
         3'd3: begin
            if (y == 32'd0) model = {x, 32'hFFFF_FFFF};
            else model = {x % y, x / y};
         end
         3'd4: model = {ph, pl} + p;
         3'd5: model = {ph, pl} - p;
         default: model = {ph, pl};
      endcase
   endfunction

   initial begin
      int dcount;
      logic [2:0] ro;
      logic [31:0] rx, ry, rh, rl;
      checks = 0; errors = 0;
      rst = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;

      vecs[0]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678, 32'h9ABCDEF0, 32'hFFFFFFFE, 32'h00000001};
      vecs[1]  = '{3'd0, 32'hFFFFFFFD, 32'h00000007, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFEB};
      vecs[2]  = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[3]  = '{3'd3, 32'h0000000A, 32'h00000000, 32'h1, 32'h2, 32'h0000000A, 32'hFFFFFFFF};
      vecs[4]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h3, 32'h4, 32'h00000000, 32'h80000000};
      vecs[5]  = '{3'd4, 32'h00000002, 32'h00000003, 32'h5, 32'h0, 32'h00000005, 32'h00000006};
      vecs[6]  = '{3'd5, 32'h00000001, 32'h00000007, 32'h0, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFC};
      vecs[7]  = '{3'd2, 32'h00000007, 32'h00000000, 32'h0, 32'h0, 32'h00000007, 32'hFFFFFFFF};
      vecs[8]  = '{3'd3, 32'hFFFFFFFF, 32'h00000010, 32'h0, 32'h0, 32'h0000000F, 32'h0FFFFFFF};
      vecs[9]  = '{3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h0, 32'h0, 32'h00000001, 32'hFFFFFFFD};
      vecs[10] = '{3'd4, 32'h00000001, 32'h00000001, 32'h0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000};
      vecs[11] = '{3'd0, 32'h80000000, 32'h80000000, 32'h0, 32'h0, 32'h40000000, 32'h00000000};

      repeat (2) @(posedge clk);
      #1;
      check("reset_hilo", {hi, lo}, 64'd0);
      check("reset_ctl", 64'({busy, done, stall}), 64'd0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 12; i++) begin
         preset(vecs[i].pre_hi, vecs[i].pre_lo);
         launch(vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].exp_hi, vecs[i].exp_lo});
         wait_done($sformatf("vec%0d", i), 1'b0);
      end

      for (int i = 0; i < 8; i++) begin
         ro = 3'($urandom_range(0, 5));
         rx = $urandom; ry = $urandom; rh = $urandom; rl = $urandom;
         if (i == 1) ry = 32'($urandom_range(1, 9));
         preset(rh, rl);
         launch(ro, rx, ry, model(ro, rx, ry, rh, rl));
         wait_done($sformatf("rand%0d", i), 1'b0);
      end

      // Start while busy must be ignored
      preset(32'h0, 32'h0);
      launch(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, {32'hFFFFFFFE, 32'h00000001});
      wait_done("busy_start", 1'b1);

      // Flush mid-RUN of DIVU
      preset(32'h11, 32'h22);
      start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
      tick();
      start = 1'b0;
      repeat (10) tick();
      check("flush_pre_busy", 64'(busy), 64'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_busy", 64'(busy), 64'd0);
      check("flush_hold", {hi, lo}, {32'h11, 32'h22});
      dcount = 0;
      repeat (40) begin tick(); if (done) dcount++; end
      check("flush_nodone", 64'(dcount), 64'd0);
      check("flush_hold2", {hi, lo}, {32'h11, 32'h22});

      // Flush beats a same-cycle Start
      start = 1'b1; flush = 1'b1; op = 3'd0; a = 32'd3; b = 32'd3;
      tick();
      start = 1'b0; flush = 1'b0;
      check("flush_start_busy", 64'(busy), 64'd0);

      // Asynchronous reset mid-RUN of MULT
      preset(32'h5, 32'h6);
      start = 1'b1; op = 3'd0; a = 32'd9; b = 32'd9;
      tick();
      start = 1'b0;
      repeat (5) tick();
      rst = 1'b1;
      #1;
      check("rst_mid_hilo", {hi, lo}, 64'd0);
      check("rst_mid_busy", 64'(busy), 64'd0);
      tick();
      rst = 1'b0;
      dcount = 0;
      repeat (40) begin tick(); if (done) dcount++; end
      check("rst_nodone", 64'(dcount), 64'd0);
      check("rst_hilo_after", {hi, lo}, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
